// File: rtl/fdtd_pkg.sv
// fdtd_pkg: field-select and loader-state types shared by the FDTD field loader
package fdtd_pkg;
  localparam int FDTD_WORD_BYTES = 4;
  typedef enum logic [1:0] {
    FLD_HY,
    FLD_EZ,
    FLD_SRC,
    FLD_BAD
  } fld_sel_e;
  typedef enum logic [2:0] {
    LD_IDLE,
    LD_START,
    LD_GAP,
    LD_FETCH,
    LD_END,
    LD_DONE
  } ld_state_e;
endpackage

// File: rtl/fdtd_field_loader_if.sv
// fdtd_field_loader_if: core-style data memory read port (req/gnt/rvalid, in-order responses)
interface fdtd_field_loader_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          data_req;
  logic [AW-1:0] data_addr;
  logic          data_we;
  logic [3:0]    data_be;
  logic          data_gnt;
  logic          data_rvalid;
  logic [DW-1:0] data_rdata;
  modport master (
    output data_req, data_addr, data_we, data_be,
    input  data_gnt, data_rvalid, data_rdata
  );
  modport slave (
    input  data_req, data_addr, data_we, data_be,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/fdtd_ld_req_gen.sv
// fdtd_ld_req_gen: read address generation, issue limiting and outstanding-read tracking
module fdtd_ld_req_gen
  import fdtd_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      clr,
  input  logic                      en,
  input  logic [MEM_ADDR_WIDTH-1:0] base,
  input  logic [LEN_WIDTH-1:0]      len,
  output logic                      rx_valid,
  output logic [LEN_WIDTH-1:0]      received,
  fdtd_field_loader_if.master       mem
);
  logic [LEN_WIDTH-1:0] issued;
  logic [1:0]           outstanding;
  logic                 fire;
  // req depends only on registered state, so it and the address hold steady until granted
  assign mem.data_req  = en && issued < len && outstanding < 2'(MAX_OUTSTANDING);
  assign mem.data_addr = base + (MEM_ADDR_WIDTH'(issued) << $clog2(FDTD_WORD_BYTES));
  assign mem.data_we   = 1'b0;
  assign mem.data_be   = 4'hF;
  assign fire          = mem.data_req && mem.data_gnt;
  assign rx_valid      = mem.data_rvalid && outstanding != 2'd0;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      issued      <= '0;
      received    <= '0;
      outstanding <= '0;
    end else begin
      if (clr) begin
        issued   <= '0;
        received <= '0;
      end else begin
        if (fire) issued <= issued + LEN_WIDTH'(1);
        if (rx_valid) received <= received + LEN_WIDTH'(1);
      end
      outstanding <= outstanding + 2'(fire) - 2'(rx_valid);
    end
endmodule

// File: rtl/fdtd_field_loader.sv
// fdtd_field_loader: DMA fetch of one FDTD field array (Hy, Ez or source) into the buffer write side
// Define FDTD_LOADER_PERF_EN to build the request-stall performance counter.
module fdtd_field_loader
  import fdtd_pkg::*;
#(
  parameter int FDTD_DATA_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH       = 16,
  parameter int MAX_LEN         = 64,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [1:0]                 cmd_sel_i,
  input  logic [MEM_ADDR_WIDTH-1:0]  cmd_base_addr_i,
  input  logic [LEN_WIDTH-1:0]       cmd_len_i,
  fdtd_field_loader_if.master        mem,
  output logic                       buffer_Hy_start_o,
  output logic                       buffer_Ez_start_o,
  output logic                       buffer_src_start_o,
  output logic                       buffer_Hy_end_o,
  output logic                       buffer_Ez_end_o,
  output logic                       buffer_src_end_o,
  output logic                       wrtvalid_Hy_old_o,
  output logic                       wrtvalid_Ez_old_o,
  output logic [FDTD_DATA_WIDTH-1:0] Hy_old_o,
  output logic [FDTD_DATA_WIDTH-1:0] Ez_old_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [15:0]                perf_stall_cnt_o
);
  ld_state_e                 state_q, state_d;
  fld_sel_e                  sel_q;
  logic [MEM_ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]      len_q, len_c, received;
  logic                      accept, rx_valid, last_out, clamp;
  assign accept   = cmd_valid_i && state_q == LD_IDLE;
  assign clamp    = cmd_len_i > LEN_WIDTH'(MAX_LEN);
  assign len_c    = clamp ? LEN_WIDTH'(MAX_LEN) : cmd_len_i;
  assign last_out = (wrtvalid_Hy_old_o || wrtvalid_Ez_old_o) && received == len_q;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state_q <= LD_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_IDLE:  state_d = !cmd_valid_i ? LD_IDLE : fld_sel_e'(cmd_sel_i) == FLD_BAD ? LD_DONE : LD_START;
      LD_START: state_d = LD_GAP;
      LD_GAP:   state_d = len_q == '0 ? LD_END : LD_FETCH;
      LD_FETCH: state_d = last_out ? LD_END : LD_FETCH;
      LD_END:   state_d = LD_DONE;
      default:  state_d = LD_IDLE;
    endcase
    cmd_ready_o        = state_q == LD_IDLE;
    busy_o             = state_q != LD_IDLE;
    done_o             = state_q == LD_DONE;
    buffer_Hy_start_o  = state_q == LD_START && sel_q == FLD_HY;
    buffer_Ez_start_o  = state_q == LD_START && sel_q == FLD_EZ;
    buffer_src_start_o = state_q == LD_START && sel_q == FLD_SRC;
    buffer_Hy_end_o    = state_q == LD_END && sel_q == FLD_HY;
    buffer_Ez_end_o    = state_q == LD_END && sel_q == FLD_EZ;
    buffer_src_end_o   = state_q == LD_END && sel_q == FLD_SRC;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      sel_q  <= FLD_HY;
      base_q <= '0;
      len_q  <= '0;
      err_o  <= 1'b0;
    end else if (accept) begin
      sel_q  <= fld_sel_e'(cmd_sel_i);
      base_q <= cmd_base_addr_i;
      len_q  <= len_c;
      err_o  <= clamp || fld_sel_e'(cmd_sel_i) == FLD_BAD;
    end
  // the source array shares the Ez write path of the buffer
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      wrtvalid_Hy_old_o <= 1'b0;
      wrtvalid_Ez_old_o <= 1'b0;
      Hy_old_o          <= '0;
      Ez_old_o          <= '0;
    end else begin
      wrtvalid_Hy_old_o <= rx_valid && sel_q == FLD_HY;
      wrtvalid_Ez_old_o <= rx_valid && sel_q != FLD_HY;
      if (rx_valid && sel_q == FLD_HY) Hy_old_o <= mem.data_rdata;
      if (rx_valid && sel_q != FLD_HY) Ez_old_o <= mem.data_rdata;
    end
  fdtd_ld_req_gen #(
    .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
    .LEN_WIDTH      (LEN_WIDTH),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_req_gen (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .clr     (accept),
    .en      (state_q == LD_FETCH),
    .base    (base_q),
    .len     (len_q),
    .rx_valid(rx_valid),
    .received(received),
    .mem     (mem)
  );
`ifdef FDTD_LOADER_PERF_EN
  logic [15:0] stall_q;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) stall_q <= '0;
    else if (accept) stall_q <= '0;
    else if (mem.data_req && !mem.data_gnt && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  assign perf_stall_cnt_o = stall_q;
`else
  assign perf_stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_fdtd_field_loader.sv
// tb_fdtd_field_loader: randomized memory responder and per-command reference checks for fdtd_field_loader
module tb_fdtd_field_loader;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_sel = '0;
  logic [31:0] cmd_base = '0;
  logic [15:0] cmd_len = '0;
  logic        hy_s, ez_s, src_s, hy_e, ez_e, src_e, wv_hy, wv_ez, busy_o, done_o, err_o;
  logic [31:0] Hy_old_o, Ez_old_o;
  logic [15:0] perf_stall_cnt_o;
  always #5 CLK = ~CLK;
  fdtd_field_loader_if #(.DW(32), .AW(32)) mem_if ();
  fdtd_field_loader dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_sel_i(cmd_sel),
    .cmd_base_addr_i(cmd_base), .cmd_len_i(cmd_len), .mem(mem_if),
    .buffer_Hy_start_o(hy_s), .buffer_Ez_start_o(ez_s), .buffer_src_start_o(src_s),
    .buffer_Hy_end_o(hy_e), .buffer_Ez_end_o(ez_e), .buffer_src_end_o(src_e),
    .wrtvalid_Hy_old_o(wv_hy), .wrtvalid_Ez_old_o(wv_ez),
    .Hy_old_o(Hy_old_o), .Ez_old_o(Ez_old_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .perf_stall_cnt_o(perf_stall_cnt_o)
  );
  int n_cmp = 0, n_bad = 0;
  logic [31:0] mem_arr [0:1023];
  typedef struct { logic [31:0] a; int due; } rd_t;
  rd_t pend[$];
  int cyc = 0, cfg_stall = 0, rv_delay = 1, stall_left = 0;
  int clr_tok = 0, clr_seen = 0, stray_tok = 0, stray_seen = 0;
  logic [31:0] addr_log[$], hy_log[$], ez_log[$];
  int nstart, nend, ndone, start_mask, end_mask, start_cyc, end_cyc, done_cyc, first_v, last_v, max_out, unstable;
  logic prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;
  // memory model and output monitor: responses are driven on the falling edge, outputs sampled there too
  always @(negedge CLK) begin
    cyc++;
    if (clr_tok != clr_seen) begin
      clr_seen = clr_tok;
      stall_left = cfg_stall;
      addr_log.delete(); hy_log.delete(); ez_log.delete();
      nstart = 0; nend = 0; ndone = 0; start_mask = 0; end_mask = 0;
      start_cyc = -1; end_cyc = -1; done_cyc = -1; first_v = -1; last_v = -1; max_out = 0; unstable = 0;
    end
    mem_if.data_gnt = 1'b0;
    mem_if.data_rvalid = 1'b0;
    mem_if.data_rdata = $urandom;
    if (!RST_N) begin
      pend.delete();
      prev_wait = 1'b0;
    end else begin
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        mem_if.data_rvalid = 1'b1;
        mem_if.data_rdata = mem_arr[pend[0].a[11:2]];
        void'(pend.pop_front());
      end else if (stray_tok != stray_seen) begin
        stray_seen = stray_tok;
        mem_if.data_rvalid = 1'b1;
      end
      if (prev_wait && (!mem_if.data_req || mem_if.data_addr !== prev_addr)) unstable++;
      mem_if.data_gnt = mem_if.data_req && stall_left == 0;
      if (mem_if.data_req && stall_left > 0) stall_left--;
      if (mem_if.data_req && mem_if.data_gnt) begin
        pend.push_back('{a: mem_if.data_addr, due: cyc + rv_delay});
        addr_log.push_back(mem_if.data_addr);
      end
      prev_wait = mem_if.data_req && !mem_if.data_gnt;
      prev_addr = mem_if.data_addr;
      if (pend.size() > max_out) max_out = pend.size();
    end
    if (wv_hy) hy_log.push_back(Hy_old_o);
    if (wv_ez) ez_log.push_back(Ez_old_o);
    if (wv_hy || wv_ez) begin
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
    if (hy_s || ez_s || src_s) begin
      nstart++; start_cyc = cyc; start_mask |= int'({src_s, ez_s, hy_s});
    end
    if (hy_e || ez_e || src_e) begin
      nend++; end_cyc = cyc; end_mask |= int'({src_e, ez_e, hy_e});
    end
    if (done_o) begin
      ndone++; done_cyc = cyc;
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_cmd(input logic [1:0] sel, input logic [31:0] base, input int len, input int stall, input int dly);
    int el, acc, errs;
    bit bad;
    logic [31:0] got[$];
    bad = sel == 2'd3;
    el = bad ? 0 : (len > 64 ? 64 : len);
    cfg_stall = stall;
    rv_delay = dly;
    clr_tok++;
    cmd_valid = 1'b1; cmd_sel = sel; cmd_base = base; cmd_len = 16'(len);
    @(posedge CLK); #1;
    acc = cyc;
    chk("busy_after_accept", {busy_o, cmd_ready}, 2'b10);
    // a second command while busy must be ignored
    cmd_sel = 2'($urandom); cmd_len = 16'($urandom_range(1, 20)); cmd_base = 32'($urandom_range(0, 255)) << 2;
    @(posedge CLK); #1 cmd_valid = 1'b0;
    for (int t = 0; t < 600 && ndone == 0; t++) @(posedge CLK);
    repeat (3) @(posedge CLK);
    #1;
    chk("done_pulses", ndone, 1);
    chk("start_pulses", nstart, bad ? 0 : 1);
    chk("end_pulses", nend, bad ? 0 : 1);
    chk("start_field", start_mask, bad ? 0 : (1 << sel));
    chk("end_field", end_mask, bad ? 0 : (1 << sel));
    chk("grants", addr_log.size(), el);
    errs = 0;
    foreach (addr_log[i]) if (addr_log[i] !== base + 32'(4 * i)) errs++;
    chk("addr_seq", errs, 0);
    if (sel == 2'd0) begin
      got = hy_log;
      chk("other_field_valids", ez_log.size(), 0);
    end else begin
      got = ez_log;
      chk("other_field_valids", hy_log.size(), 0);
    end
    chk("words", got.size(), el);
    errs = 0;
    for (int i = 0; i < el; i++)
      if (i >= got.size() || got[i] !== mem_arr[int'(base >> 2) + i]) errs++;
    chk("word_data", errs, 0);
    if (bad) chk("done_latency", done_cyc, acc + 1);
    else begin
      chk("start_latency", start_cyc, acc + 1);
      chk("end_latency", end_cyc, el == 0 ? start_cyc + 2 : last_v + 1);
      chk("done_latency", done_cyc, end_cyc + 1);
      if (el > 0) chk("first_valid_gap", first_v >= start_cyc + 2, 1);
    end
    chk("max_outstanding", max_out <= 2, 1);
    chk("addr_stable", unstable, 0);
    chk("err", err_o, len > 64 || bad);
`ifdef FDTD_LOADER_PERF_EN
    chk("perf_stall", perf_stall_cnt_o, el > 0 ? stall : 0);
`else
    chk("perf_stall", perf_stall_cnt_o, 0);
`endif
    chk("idle_after", {busy_o, cmd_ready}, 2'b01);
  endtask
  initial begin
    foreach (mem_arr[i]) mem_arr[i] = $urandom;
    #1 RST_N = 1'b0;
    #1;
    chk("rst_ctrl", {cmd_ready, busy_o, done_o, err_o, mem_if.data_req}, 5'b10000);
    chk("rst_frame", {hy_s, ez_s, src_s, hy_e, ez_e, src_e, wv_hy, wv_ez}, 8'h00);
    chk("rst_data", {Hy_old_o, Ez_old_o, mem_if.data_addr}, 96'h0);
    chk("rst_perf", perf_stall_cnt_o, 0);
    chk("we_be", {mem_if.data_we, mem_if.data_be}, 5'h0F);
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    run_cmd(2'd0, 32'h100, 4, 0, 1);
    run_cmd(2'd1, 32'h300, 3, 5, 1);
    run_cmd(2'd2, 32'h500, 8, 0, 3);
    run_cmd(2'd0, 32'h200, 100, 0, 1);
    run_cmd(2'd1, 32'h000, 0, 0, 1);
    run_cmd(2'd3, 32'h040, 5, 0, 1);
    // reset in the middle of a 6-word Hy frame, then a stray read response
    cfg_stall = 0; rv_delay = 1; clr_tok++;
    cmd_valid = 1'b1; cmd_sel = 2'd0; cmd_base = 32'h40; cmd_len = 16'd6;
    @(posedge CLK); #1 cmd_valid = 1'b0;
    for (int t = 0; t < 100 && hy_log.size() < 2; t++) @(posedge CLK);
    #1 RST_N = 1'b0;
    clr_tok++;
    #1;
    chk("midrst_ctrl", {mem_if.data_req, busy_o, cmd_ready, wv_hy, done_o}, 5'b00100);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK); #1 stray_tok++;
    repeat (6) @(posedge CLK);
    #1;
    chk("midrst_valids", hy_log.size() + ez_log.size(), 0);
    chk("midrst_framing", nstart + nend + ndone, 0);
    chk("midrst_grants", addr_log.size(), 0);
    chk("midrst_idle", {busy_o, cmd_ready}, 2'b01);
    for (int k = 0; k < 8; k++)
      run_cmd(2'($urandom_range(0, 2)), 32'($urandom_range(0, 900)) << 2, $urandom_range(0, 70),
              $urandom_range(0, 4), $urandom_range(1, 3));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
